axis_bandwidth_shaper: RTL and testbench

In-line AXI-Stream rate limiter. It enforces a programmed beat budget per fixed window of 2^WINDOW_WIDTH clock cycles, which makes it the enforcing counterpart to the passive valid/ready bandwidth monitor on the same streams. It sits between a RoCE TX source and the downstream MAC/FIFO and throttles by gating valid and ready together. In packet mode it stops only at tlast boundaries; any beats it overdraws are carried into the next window as debt.

---
 rtl/axis_bandwidth_shaper.sv | 131 +++++++++++++
 tb/tb_axis_bandwidth_shaper.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bandwidth_shaper.sv
// In-line AXI-Stream rate limiter: beat budget per 2^WINDOW_WIDTH-cycle window, packet-aware with debt carry.
// Optional stall statistics are enabled by defining AXIS_BANDWIDTH_SHAPER_STATS_EN.
module axis_bandwidth_shaper #(
   parameter int unsigned DATA_WIDTH   = 512,
   parameter int unsigned KEEP_WIDTH   = DATA_WIDTH/8,
   parameter int unsigned WINDOW_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   input  logic                    cfg_enable,
   input  logic                    cfg_pkt_mode,
   input  logic [WINDOW_WIDTH-1:0] cfg_rate_beats,
   output logic [WINDOW_WIDTH-1:0] credit_left,
   output logic                    throttled,
   output logic [WINDOW_WIDTH-1:0] stall_cycles
);

   typedef enum logic [1:0] {RUN, DRAIN, BLOCK} state_t;

   localparam logic [WINDOW_WIDTH-1:0] ONE = WINDOW_WIDTH'(1);

   state_t                  state, state_nxt;
   logic [WINDOW_WIDTH-1:0] win_ctr;
   logic [WINDOW_WIDTH-1:0] credit, credit_nxt;
   logic [WINDOW_WIDTH-1:0] debt, debt_nxt;
   logic [WINDOW_WIDTH-1:0] reload;
   logic                    wrap;
   logic                    allow;
   logic                    beat;

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tvalid = s_axis_tvalid & allow;
   assign s_axis_tready = m_axis_tready & allow;
   assign beat          = m_axis_tvalid & m_axis_tready;

   assign wrap        = (win_ctr == '1);
   assign reload      = (cfg_rate_beats > debt) ? (cfg_rate_beats - debt) : '0;
   assign credit_left = credit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= BLOCK;
         win_ctr <= '1;
         credit  <= '0;
         debt    <= '0;
      end else begin
         state   <= state_nxt;
         win_ctr <= win_ctr + 1'b1;
         credit  <= credit_nxt;
         debt    <= debt_nxt;
      end
   end

   // Reload wins over any beat in the wrap cycle; a DRAIN wrap with no new credit keeps the packet whole.
   always_comb begin
      state_nxt  = state;
      credit_nxt = credit;
      debt_nxt   = debt;
      if (wrap) begin
         credit_nxt = reload;
         debt_nxt   = '0;
         if (reload != '0)
            state_nxt = RUN;
         else if ((state == DRAIN) && !(beat && s_axis_tlast))
            state_nxt = DRAIN;
         else
            state_nxt = BLOCK;
      end else begin
         unique case (state)
            RUN: begin
               if (beat) begin
                  credit_nxt = credit - 1'b1;
                  if (credit == ONE)
                     state_nxt = (cfg_pkt_mode && !s_axis_tlast) ? DRAIN : BLOCK;
               end
            end
            DRAIN: begin
               if (beat) begin
                  if (debt != '1)
                     debt_nxt = debt + 1'b1;
                  if (s_axis_tlast)
                     state_nxt = BLOCK;
               end
            end
            default: ;
         endcase
      end
   end

   // Gating with rst_n holds both handshake sides closed while reset is asserted, even with shaping off.
   always_comb begin
      allow     = rst_n & (!cfg_enable | (state != BLOCK));
      throttled = !rst_n | (cfg_enable & (state == BLOCK));
   end

`ifdef AXIS_BANDWIDTH_SHAPER_STATS_EN
   logic [WINDOW_WIDTH-1:0] stall_ctr;
   logic [WINDOW_WIDTH-1:0] stall_q;
   logic                    stall;

   assign stall        = s_axis_tvalid & !allow & cfg_enable;
   assign stall_cycles = stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_ctr <= '0;
         stall_q   <= '0;
      end else if (wrap) begin
         stall_q   <= stall_ctr;
         stall_ctr <= WINDOW_WIDTH'(stall);
      end else if (stall && (stall_ctr != '1)) begin
         stall_ctr <= stall_ctr + 1'b1;
      end
   end
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_axis_bandwidth_shaper.sv
// Scoreboard bench for axis_bandwidth_shaper with a 16-cycle window; stall expectations follow AXIS_BANDWIDTH_SHAPER_STATS_EN.
module tb_axis_bandwidth_shaper;

   localparam int unsigned DW = 64;
   localparam int unsigned KW = 8;
   localparam int unsigned WW = 4;
`ifdef AXIS_BANDWIDTH_SHAPER_STATS_EN
   localparam logic [WW-1:0] EXP_STALL = 4'd11;
`else
   localparam logic [WW-1:0] EXP_STALL = 4'd0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic [KW-1:0] s_tkeep = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b1;
   logic          cfg_enable = 1'b0;
   logic          cfg_pkt_mode = 1'b0;
   logic [WW-1:0] cfg_rate = '0;
   logic [WW-1:0] credit_left;
   logic          throttled;
   logic [WW-1:0] stall_cycles;

   beat_t       exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned data_k = 0;
   int unsigned pkt_pos = 0;
   logic        presented = 1'b0;

   logic          samp_fire, samp_beat, samp_thr;
   logic [WW-1:0] samp_credit, samp_stall;
   logic [15:0]   bmask, tmask;
   logic [WW-1:0] win_cred[16];
   logic [WW-1:0] stall0;
   int            nbeats;

   always #5 clk = ~clk;

   axis_bandwidth_shaper #(
      .DATA_WIDTH  (DW),
      .KEEP_WIDTH  (KW),
      .WINDOW_WIDTH(WW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .cfg_enable    (cfg_enable),
      .cfg_pkt_mode  (cfg_pkt_mode),
      .cfg_rate_beats(cfg_rate),
      .credit_left   (credit_left),
      .throttled     (throttled),
      .stall_cycles  (stall_cycles)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Each new source word is pushed as the response the sink must eventually see, in order.
   task automatic present_new();
      beat_t b;
      b.data = {data_k ^ 32'hA5A5_5A5A, data_k};
      b.keep = data_k[7:0] ^ 8'h3C;
      b.last = (pkt_pos == 7);
      s_tdata = b.data;
      s_tkeep = b.keep;
      s_tlast = b.last;
      exp_q.push_back(b);
      presented = 1'b1;
   endtask

   task automatic advance();
      data_k++;
      pkt_pos = (pkt_pos + 1) % 8;
      present_new();
   endtask

   task automatic src_withdraw();
      if (presented && exp_q.size() > 0) void'(exp_q.pop_back());
      presented = 1'b0;
   endtask

   task automatic src_restart();
      src_withdraw();
      pkt_pos = 0;
      data_k++;
      present_new();
   endtask

   task automatic step();
      @(negedge clk);
      samp_fire   = s_tvalid & s_tready;
      samp_beat   = m_tvalid & m_tready;
      samp_thr    = throttled;
      samp_credit = credit_left;
      samp_stall  = stall_cycles;
      @(posedge clk);
      #1;
      if (samp_fire) advance();
   endtask

   task automatic run_window(input int ready_mode, input int nvoff);
      bmask  = '0;
      tmask  = '0;
      nbeats = 0;
      for (int i = 0; i < 16; i++) begin
         m_tready = (ready_mode == 0) ? 1'b1 : ((i % 2) == 0);
         s_tvalid = (i >= nvoff);
         step();
         bmask[i]    = samp_beat;
         tmask[i]    = samp_thr;
         win_cred[i] = samp_credit;
         if (i == 0) stall0 = samp_stall;
         nbeats += int'(samp_beat);
      end
      m_tready = 1'b1;
      s_tvalid = 1'b1;
   endtask

   task automatic do_reset(input logic en, input logic pm, input logic [WW-1:0] rate);
      rst_n        = 1'b0;
      cfg_enable   = en;
      cfg_pkt_mode = pm;
      cfg_rate     = rate;
      m_tready     = 1'b1;
      s_tvalid     = 1'b1;
      src_restart();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
   endtask

   always @(negedge clk) begin
      beat_t got, e;
      if (rst_n) begin
         if (!s_tvalid) begin
            checks++;
            if (m_tvalid) begin
               errors++;
               $display("FAIL valid_gate: m_axis_tvalid=1 required 0");
            end
         end
         if (m_tvalid && m_tready) begin
            checks++;
            got = {m_tdata, m_tkeep, m_tlast};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow: unexpected beat %0h", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL sb_beat: got %0h required %0h", got, e);
               end
            end
         end
      end
   end

   logic [15:0]   t2_b[4] = '{16'h00FF, 16'h00FF, 16'h0000, 16'h00FF};
   logic [15:0]   t2_t[4] = '{16'hFF00, 16'hFF00, 16'hFFFF, 16'hFF00};
   logic [WW-1:0] t2_c[4] = '{4'd5, 4'd2, 4'd0, 4'd5};

   initial begin
      // 1 + stats: rate 5, word mode
      do_reset(1'b1, 1'b0, 4'd5);
      for (int w = 0; w < 3; w++) begin
         run_window(0, 0);
         chk("t1_beat_mask", bmask, 16'h001F);
         chk("t1_thr_mask", tmask, 16'hFFE0);
         chk("t1_nbeats", nbeats, 5);
         chk("t1_credit0", win_cred[0], 5);
         chk("t1_credit3", win_cred[3], 2);
         chk("t1_credit5", win_cred[5], 0);
         chk("t1_stall", stall0, (w == 0) ? 4'd0 : EXP_STALL);
      end

      // 2: packet mode, 8-beat packets, debt carry
      do_reset(1'b1, 1'b1, 4'd5);
      for (int w = 0; w < 4; w++) begin
         run_window(0, 0);
         chk("t2_beat_mask", bmask, t2_b[w]);
         chk("t2_thr_mask", tmask, t2_t[w]);
         chk("t2_credit0", win_cred[0], t2_c[w]);
      end

      // 3: shaping disabled with zero rate, then enable mid-window
      do_reset(1'b0, 1'b0, 4'd0);
      for (int w = 0; w < 2; w++) begin
         run_window(0, 0);
         chk("t3_beat_mask", bmask, 16'hFFFF);
         chk("t3_thr_mask", tmask, 16'h0000);
      end
      repeat (5) step();
      cfg_enable = 1'b1;
      step();
      chk("t3_en_beat", samp_beat, 0);
      chk("t3_en_thr", samp_thr, 1);
      chk("t3_en_credit", samp_credit, 0);
      repeat (10) step();

      // 4: sink ready 50%, then source idle at window start
      do_reset(1'b1, 1'b0, 4'd5);
      for (int w = 0; w < 2; w++) begin
         run_window(1, 0);
         chk("t4_beat_mask", bmask, 16'h0155);
         chk("t4_nbeats", nbeats, 5);
         chk("t4_thr_mask", tmask, 16'hFE00);
      end
      run_window(0, 3);
      chk("t4_idle_mask", bmask, 16'h00F8);
      chk("t4_idle_thr", tmask, 16'hFF00);

      // 5: reset mid-packet while debt is outstanding
      do_reset(1'b1, 1'b1, 4'd5);
      run_window(0, 0);
      step();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_mvalid", m_tvalid, 0);
      chk("t5_rst_sready", s_tready, 0);
      chk("t5_rst_thr", throttled, 1);
      chk("t5_rst_credit", credit_left, 0);
      do_reset(1'b1, 1'b1, 4'd5);
      run_window(0, 0);
      chk("t5_credit0", win_cred[0], 5);
      chk("t5_beat_mask", bmask, 16'h00FF);

      s_tvalid = 1'b0;
      src_withdraw();
      repeat (3) step();
      chk("sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
